pc_fetch_unit: RTL and testbench

//  Program-counter stage feeding the instruction memory. Holds the architectural PC and selects
//  the next PC: sequential, branch, jump or jump-register. Drives the word address into IMEM.

---
 rtl/pc_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter stage feeding the instruction memory.
// Holds the architectural PC, selects the next PC (seq/branch/jump/jr),
// drives the IMEM word address and counts PC advances. A misaligned redirect
// target traps into HALT; HALT is left only through reset.
// Optional feature: define PC_EXC_EN to add exception entry (exc_req) and
// return (eret) with an exception PC register (epc_out).
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter int unsigned IMEM_AW    = 11
`ifdef PC_EXC_EN
  ,
  parameter logic [31:0] EXC_VECTOR = 32'h0040_0004
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               halt_req,
  input  logic [2:0]         pc_sel,
  input  logic               br_taken,
  input  logic [15:0]        br_imm,
  input  logic [25:0]        j_index,
  input  logic [31:0]        jr_target,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               fetch_valid,
  output logic [1:0]         state,
  output logic               misalign_err,
  output logic [31:0]        fetch_cnt
`ifdef PC_EXC_EN
  ,
  input  logic               exc_req,
  input  logic               eret,
  input  logic [31:0]        epc_in,
  output logic [31:0]        epc_out
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] next_pc;
  logic [31:0] br_off;
`ifdef PC_EXC_EN
  logic [31:0] epc_q, epc_d;
`endif

  assign pc_plus4     = pc_q + 32'd4;
  assign br_off       = {{14{br_imm[15]}}, br_imm, 2'b00};
  // Offset from the IMEM base, truncated to the word address; wraps silently.
  assign imem_addr    = IMEM_AW'((pc_q - RESET_PC) >> 2);
  assign fetch_valid  = (state_q == ST_RUN) && !stall;
  assign state        = state_q;
  assign pc           = pc_q;
  assign misalign_err = err_q;
  assign fetch_cnt    = cnt_q;
`ifdef PC_EXC_EN
  assign epc_out      = epc_q;
`endif

  // Next-PC selection; reserved encodings fall back to sequential.
  always_comb begin
    next_pc = pc_plus4;
    case (pc_sel)
      3'b001:  next_pc = br_taken ? (pc_plus4 + br_off) : pc_plus4;
      3'b010:  next_pc = {pc_plus4[31:28], j_index, 2'b00};
      3'b011:  next_pc = jr_target;
      default: next_pc = pc_plus4;
    endcase
  end

  // Next-state logic: exception > stall > halt_req > misalign > normal update.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
`ifdef PC_EXC_EN
    epc_d   = epc_q;
    if (exc_req && (state_q != ST_BOOT)) begin
      epc_d   = pc_q;
      pc_d    = EXC_VECTOR;
      state_d = ST_RUN;
      cnt_d   = cnt_q + 32'd1;
    end else
`endif
    begin
      case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN: begin
          if (!stall) begin
            if (halt_req) begin
              state_d = ST_HALT;
            end
`ifdef PC_EXC_EN
            else if (eret) begin
              pc_d  = epc_in + 32'd4;
              cnt_d = cnt_q + 32'd1;
            end
`endif
            else if (next_pc[1:0] != 2'b00) begin
              err_d   = 1'b1;
              state_d = ST_HALT;
            end else begin
              pc_d  = next_pc;
              cnt_d = cnt_q + 32'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef PC_EXC_EN
      epc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef PC_EXC_EN
      epc_q   <= epc_d;
`endif
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed scenarios followed by randomized
// stimulus, all outputs compared against a behavioural model every cycle.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] EXC_PC = 32'h0040_0004;

  logic        clk = 1'b0;
  logic        rst_n, stall, halt_req, br_taken;
  logic [2:0]  pc_sel;
  logic [15:0] br_imm;
  logic [25:0] j_index;
  logic [31:0] jr_target;
  logic [31:0] pc, pc_plus4, fetch_cnt;
  logic [10:0] imem_addr;
  logic        fetch_valid, misalign_err;
  logic [1:0]  state;
`ifdef PC_EXC_EN
  logic        exc_req, eret;
  logic [31:0] epc_in, epc_out;
  logic [31:0] m_epc;
`endif

  // Reference model state: 0 boot, 1 run, 2 halt
  logic [31:0] m_pc, m_cnt;
  int          m_st;
  logic        m_err;
  int          n_tests, n_fail;

  always #5 clk = ~clk;

  pc_fetch_unit #(
    .RESET_PC (RST_PC),
    .IMEM_AW  (11)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .halt_req     (halt_req),
    .pc_sel       (pc_sel),
    .br_taken     (br_taken),
    .br_imm       (br_imm),
    .j_index      (j_index),
    .jr_target    (jr_target),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .imem_addr    (imem_addr),
    .fetch_valid  (fetch_valid),
    .state        (state),
    .misalign_err (misalign_err),
    .fetch_cnt    (fetch_cnt)
`ifdef PC_EXC_EN
    ,
    .exc_req      (exc_req),
    .eret         (eret),
    .epc_in       (epc_in),
    .epc_out      (epc_out)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Redirect target from the instruction-level rules.
  function automatic logic [31:0] model_target();
    int signed woff;
    woff = int'($signed(br_imm));
    case (pc_sel)
      3'd1:    return br_taken ? (m_pc + 32'd4 + 32'(woff * 4)) : (m_pc + 32'd4);
      3'd2:    return ((m_pc + 32'd4) & 32'hF000_0000) | (32'(j_index) * 32'd4);
      3'd3:    return jr_target;
      default: return m_pc + 32'd4;
    endcase
  endfunction

  task automatic model_reset();
    m_pc  = RST_PC;
    m_cnt = 0;
    m_st  = 0;
    m_err = 1'b0;
`ifdef PC_EXC_EN
    m_epc = 0;
`endif
  endtask

  task automatic model_clock();
    logic [31:0] t;
    if (!rst_n) model_reset();
`ifdef PC_EXC_EN
    else if (exc_req && m_st != 0) begin
      m_epc = m_pc;
      m_pc  = EXC_PC;
      m_st  = 1;
      m_cnt = m_cnt + 1;
    end
`endif
    else if (m_st == 0) m_st = 1;
    else if (m_st == 1 && !stall) begin
      if (halt_req) m_st = 2;
`ifdef PC_EXC_EN
      else if (eret) begin
        m_pc  = epc_in + 4;
        m_cnt = m_cnt + 1;
      end
`endif
      else begin
        t = model_target();
        if (t % 4 != 0) begin
          m_err = 1'b1;
          m_st  = 2;
        end else begin
          m_pc  = t;
          m_cnt = m_cnt + 1;
        end
      end
    end
  endtask

  // Called at a negedge with inputs already driven: check, clock, update model.
  task automatic step();
    #1;
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("imem_addr", 32'(imem_addr), ((m_pc - RST_PC) / 4) % 2048);
    check("fetch_valid", 32'(fetch_valid), 32'((m_st == 1) && !stall));
    check("state", 32'(state), m_st);
    check("misalign_err", 32'(misalign_err), 32'(m_err));
    check("fetch_cnt", fetch_cnt, m_cnt);
`ifdef PC_EXC_EN
    check("epc_out", epc_out, m_epc);
`endif
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic s, input logic h, input logic [2:0] sel);
    rst_n    = r;
    stall    = s;
    halt_req = h;
    pc_sel   = sel;
  endtask

  logic [31:0] rnd;

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    br_taken  = 1'b0;
    br_imm    = '0;
    j_index   = '0;
    jr_target = '0;
`ifdef PC_EXC_EN
    exc_req = 1'b0;
    eret    = 1'b0;
    epc_in  = '0;
`endif
    drive(1'b0, 1'b0, 1'b0, 3'd0);
    @(posedge clk);
    @(posedge clk);
    model_reset();
    @(negedge clk);

    // T1: boot then sequential fetch
    check("T1_reset_state", 32'(state), 32'd0);
    check("T1_reset_valid", 32'(fetch_valid), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    step();
    check("T1_pc0", pc, 32'h0040_0000);
    check("T1_run", 32'(state), 32'd1);
    step();
    check("T1_pc1", pc, 32'h0040_0004);
    check("T1_ia1", 32'(imem_addr), 32'd1);
    step();
    check("T1_pc2", pc, 32'h0040_0008);
    check("T1_ia2", 32'(imem_addr), 32'd2);
    step();
    check("T1_cnt", fetch_cnt, 32'd3);
    step();
    check("T2_pre", pc, 32'h0040_0010);

    // T2: taken / not-taken branch
    drive(1'b1, 1'b0, 1'b0, 3'd1);
    br_taken = 1'b1;
    br_imm   = 16'hFFFC;
    step();
    check("T2_taken", pc, 32'h0040_0004);
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    repeat (3) step();
    drive(1'b1, 1'b0, 1'b0, 3'd1);
    br_taken = 1'b0;
    step();
    check("T2_not_taken", pc, 32'h0040_0014);

    // T3: jump, then misaligned jr
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    repeat (3) step();
    drive(1'b1, 1'b0, 1'b0, 3'd2);
    j_index = 26'h0100010;
    step();
    check("T3_jump", pc, 32'h0040_0040);
    drive(1'b1, 1'b0, 1'b0, 3'd3);
    jr_target = 32'h0040_0102;
    step();
    check("T3_jr_hold", pc, 32'h0040_0040);
    check("T3_misalign", 32'(misalign_err), 32'd1);
    check("T3_halt", 32'(state), 32'd2);

    // T4: stall holds everything, halt_req ignored while stalled
    drive(1'b0, 1'b0, 1'b0, 3'd0);
    step();
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    repeat (3) step();
    drive(1'b1, 1'b1, 1'b0, 3'd0);
    step();
    drive(1'b1, 1'b1, 1'b1, 3'd0);
    step();
    drive(1'b1, 1'b1, 1'b0, 3'd0);
    #1;
    check("T4_valid", 32'(fetch_valid), 32'd0);
    step();
    check("T4_pc", pc, 32'h0040_0008);
    check("T4_cnt", fetch_cnt, 32'd2);
    check("T4_state", 32'(state), 32'd1);

    // T5: halt, ignore jumps, reset
    drive(1'b1, 1'b0, 1'b1, 3'd0);
    step();
    check("T5_halt", 32'(state), 32'd2);
    drive(1'b1, 1'b0, 1'b0, 3'd2);
    repeat (5) step();
    check("T5_pc_fixed", pc, 32'h0040_0008);
    drive(1'b0, 1'b0, 1'b0, 3'd2);
    step();
    check("T5_rst_pc", pc, 32'h0040_0000);
    check("T5_rst_state", 32'(state), 32'd0);

`ifdef PC_EXC_EN
    // T6: exception entry and return
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    step();
    drive(1'b1, 1'b0, 1'b0, 3'd3);
    jr_target = 32'h0040_0030;
    step();
    drive(1'b1, 1'b0, 1'b0, 3'd0);
    exc_req = 1'b1;
    step();
    check("T6_exc_pc", pc, 32'h0040_0004);
    check("T6_epc", epc_out, 32'h0040_0030);
    exc_req = 1'b0;
    eret    = 1'b1;
    epc_in  = 32'h0040_0030;
    step();
    check("T6_eret", pc, 32'h0040_0034);
    eret = 1'b0;
`endif

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      rst_n    = ($urandom % 40) != 0;
      stall    = ($urandom % 4) == 0;
      halt_req = ($urandom % 60) == 0;
      pc_sel   = 3'($urandom);
      br_taken = 1'($urandom);
      br_imm   = 16'($urandom);
      j_index  = 26'($urandom);
      rnd      = $urandom;
      jr_target = (($urandom % 4) == 0) ? rnd : {rnd[31:2], 2'b00};
`ifdef PC_EXC_EN
      exc_req = ($urandom % 30) == 0;
      eret    = ($urandom % 20) == 0;
      epc_in  = {rnd[31:2], 2'b00};
`endif
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
